// File: rtl/ddr2_burst_scheduler.sv
// ddr2_burst_scheduler: time-shares a single-port DDR2 burst controller between
// write and read phases so the external memory behaves as a bounded burst FIFO.
// Burst occupancy is tracked by snooping the MIG port-0 command bus.
module ddr2_burst_scheduler #(
  parameter int unsigned DEPTH_BURSTS = 1048576,
  parameter int unsigned OCC_W        = 21,
  parameter int unsigned MARGIN       = 2,
  parameter int unsigned WR_THRESH    = 16,
  parameter int unsigned MAX_RUN      = 16,
  parameter int unsigned GAP          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear_flags,
  input  logic             calib_done,
  input  logic [8:0]       ib_count,
  input  logic             p0_cmd_en,
  input  logic [2:0]       p0_cmd_instr,
  output logic             writes_en,
  output logic             reads_en,
  output logic [OCC_W-1:0] occupancy,
  output logic             ddr_full,
  output logic             ddr_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned RUN_W = $clog2(MAX_RUN + 1);
  localparam int unsigned GAP_W = $clog2(GAP + 1);

  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(DEPTH_BURSTS);
  localparam logic [OCC_W-1:0] OCC_HI   = OCC_W'(DEPTH_BURSTS - MARGIN);
  localparam logic [OCC_W-1:0] OCC_LO   = OCC_W'(MARGIN);
  localparam logic [8:0]       IB_MIN   = 9'(WR_THRESH);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RUN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_GAP} state_t;
  typedef enum logic {PH_WRITE, PH_READ} phase_t;

  state_t           state, state_nxt;
  phase_t           last_phase, last_phase_nxt;
  logic [RUN_W-1:0] run_cnt, run_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;

  logic cmd_wr, cmd_rd, at_max, at_zero, wr_ok, rd_ok;

  // Snooped command decode and phase eligibility from the current occupancy
  always_comb begin
    cmd_wr  = p0_cmd_en && (p0_cmd_instr == INSTR_WR);
    cmd_rd  = p0_cmd_en && (p0_cmd_instr == INSTR_RD);
    at_max  = (occupancy == OCC_MAX);
    at_zero = (occupancy == '0);
    wr_ok   = calib_done && run && (occupancy <= OCC_HI) && (ib_count >= IB_MIN);
    rd_ok   = calib_done && run && (occupancy >= OCC_LO);
  end

  // Occupancy counter, registered full/empty status and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
      ddr_full  <= 1'b0;
      ddr_empty <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (cmd_wr && !at_max) begin
        occupancy <= occupancy + OCC_W'(1);
      end else if (cmd_rd && !at_zero) begin
        occupancy <= occupancy - OCC_W'(1);
      end

      ddr_full  <= (occupancy >= OCC_HI);
      ddr_empty <= (occupancy < OCC_LO);

      // A new error in the same cycle as a clear keeps the flag set
      if (cmd_wr && at_max) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end

      if (cmd_rd && at_zero) begin
        underflow <= 1'b1;
      end else if (clear_flags) begin
        underflow <= 1'b0;
      end
    end
  end

  // Phase state register; enables follow the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_phase <= PH_READ;
      run_cnt    <= '0;
      gap_cnt    <= '0;
      writes_en  <= 1'b0;
      reads_en   <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_phase <= last_phase_nxt;
      run_cnt    <= run_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      writes_en  <= (state_nxt == S_WRITE);
      reads_en   <= (state_nxt == S_READ);
    end
  end

  // Next-state: alternate phases on a tie, cap run length, then hold a guard gap
  always_comb begin
    state_nxt      = state;
    last_phase_nxt = last_phase;
    run_cnt_nxt    = run_cnt;
    gap_cnt_nxt    = gap_cnt;

    case (state)
      S_IDLE: begin
        run_cnt_nxt = '0;
        if (wr_ok && (!rd_ok || (last_phase == PH_READ))) begin
          state_nxt      = S_WRITE;
          last_phase_nxt = PH_WRITE;
        end else if (rd_ok) begin
          state_nxt      = S_READ;
          last_phase_nxt = PH_READ;
        end
      end

      S_WRITE: begin
        if (cmd_wr) begin
          run_cnt_nxt = run_cnt + RUN_W'(1);
        end
        if (!wr_ok || (run_cnt_nxt >= RUN_MAX)) begin
          state_nxt   = S_GAP;
          gap_cnt_nxt = '0;
        end
      end

      S_READ: begin
        if (cmd_rd) begin
          run_cnt_nxt = run_cnt + RUN_W'(1);
        end
        if (!rd_ok || (run_cnt_nxt >= RUN_MAX)) begin
          state_nxt   = S_GAP;
          gap_cnt_nxt = '0;
        end
      end

      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
